// File: rtl/nasti_elastic_buf_if.sv
// nasti_channel: NASTI (AXI4) link carrying the five channels AW, AR, W, B, R.
//   master modport - drives AW/AR/W payload+valid, B/R ready.
//   slave  modport - drives AW/AR/W ready, B/R payload+valid.
interface nasti_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  // write address
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;
  // read address
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;
  // write data
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;
  // write response
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;
  // read data
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_elastic_buf.sv
// nasti_buf_fifo: one channel of the elastic buffer. DEPTH>0 gives a circular
// FIFO (1-cycle latency, ready = not full); DEPTH==0 is a wire pass-through.
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and payload
module nasti_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;
    assign out_valid      = in_valid;
    assign in_ready       = out_ready;
    assign out_data       = in_data;
  end else begin : g_buf
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop;

    // Ready depends only on the registered count, so a pop in the same cycle
    // never opens a full FIFO: no out_ready -> in_ready combinational path.
    assign in_ready  = (cnt_q != CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rp_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (push) wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
      if (pop)  rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        cnt_q <= cnt_d;
      end
    end

    // Payload storage is deliberately not reset; valid masks stale entries.
    always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= in_data;
    end
  end
endmodule

// nasti_elastic_buf: NASTI register slice / elastic buffer with per-channel
// depth and an outstanding-transaction limiter for writes and reads.
//   clk, rstn            - clock, async active-low reset
//   s                    - upstream (slave modport), all five channels
//   m                    - downstream (master modport), all five channels
//   wr_out_cnt           - writes accepted on s.aw awaiting s.b
//   rd_out_cnt           - reads accepted on s.ar awaiting the last s.r beat
module nasti_elastic_buf #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int AW_DEPTH   = 2,
  parameter int AR_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int B_DEPTH    = 2,
  parameter int R_DEPTH    = 2,
  parameter int CNT_WIDTH  = 8,
  parameter int MAX_WR_OUT = 0,
  parameter int MAX_RD_OUT = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  nasti_channel.slave          s,
  nasti_channel.master         m,
  output logic [CNT_WIDTH-1:0] wr_out_cnt,
  output logic [CNT_WIDTH-1:0] rd_out_cnt
);
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
  } ax_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    last;
    logic [USER_WIDTH-1:0]   user;
  } w_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            resp;
    logic [USER_WIDTH-1:0] user;
  } b_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } r_t;

  ax_t aw_in, aw_out, ar_in, ar_out;
  w_t  w_in, w_out;
  b_t  b_in, b_out;
  r_t  r_in, r_out;

  logic                 aw_fifo_vld, aw_fifo_rdy, ar_fifo_vld, ar_fifo_rdy;
  logic                 wr_block, rd_block;
  logic                 aw_hs, b_hs, ar_hs, r_last_hs;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  // Limiter blocks on the registered count only, so it never forms a
  // combinational loop with the response channels.
  assign wr_block = (MAX_WR_OUT > 0) && (wr_cnt_q == CNT_WIDTH'(MAX_WR_OUT));
  assign rd_block = (MAX_RD_OUT > 0) && (rd_cnt_q == CNT_WIDTH'(MAX_RD_OUT));

  // Masking valid as well as ready keeps a pass-through channel from
  // handshaking downstream while the upstream side is held off.
  assign aw_fifo_vld = s.aw_valid & ~wr_block;
  assign s.aw_ready  = aw_fifo_rdy & ~wr_block;
  assign ar_fifo_vld = s.ar_valid & ~rd_block;
  assign s.ar_ready  = ar_fifo_rdy & ~rd_block;

  assign aw_in = {s.aw_id, s.aw_addr, s.aw_len, s.aw_size, s.aw_burst, s.aw_lock,
                  s.aw_cache, s.aw_prot, s.aw_qos, s.aw_region, s.aw_user};
  assign ar_in = {s.ar_id, s.ar_addr, s.ar_len, s.ar_size, s.ar_burst, s.ar_lock,
                  s.ar_cache, s.ar_prot, s.ar_qos, s.ar_region, s.ar_user};
  assign w_in  = {s.w_data, s.w_strb, s.w_last, s.w_user};
  assign b_in  = {m.b_id, m.b_resp, m.b_user};
  assign r_in  = {m.r_id, m.r_data, m.r_resp, m.r_last, m.r_user};

  assign {m.aw_id, m.aw_addr, m.aw_len, m.aw_size, m.aw_burst, m.aw_lock,
          m.aw_cache, m.aw_prot, m.aw_qos, m.aw_region, m.aw_user} = aw_out;
  assign {m.ar_id, m.ar_addr, m.ar_len, m.ar_size, m.ar_burst, m.ar_lock,
          m.ar_cache, m.ar_prot, m.ar_qos, m.ar_region, m.ar_user} = ar_out;
  assign {m.w_data, m.w_strb, m.w_last, m.w_user}           = w_out;
  assign {s.b_id, s.b_resp, s.b_user}                       = b_out;
  assign {s.r_id, s.r_data, s.r_resp, s.r_last, s.r_user}   = r_out;

  nasti_buf_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AW_DEPTH)) u_aw (
    .clk(clk), .rstn(rstn),
    .in_valid(aw_fifo_vld), .in_ready(aw_fifo_rdy), .in_data(aw_in),
    .out_valid(m.aw_valid), .out_ready(m.aw_ready), .out_data(aw_out)
  );

  nasti_buf_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AR_DEPTH)) u_ar (
    .clk(clk), .rstn(rstn),
    .in_valid(ar_fifo_vld), .in_ready(ar_fifo_rdy), .in_data(ar_in),
    .out_valid(m.ar_valid), .out_ready(m.ar_ready), .out_data(ar_out)
  );

  nasti_buf_fifo #(.WIDTH($bits(w_t)), .DEPTH(W_DEPTH)) u_w (
    .clk(clk), .rstn(rstn),
    .in_valid(s.w_valid), .in_ready(s.w_ready), .in_data(w_in),
    .out_valid(m.w_valid), .out_ready(m.w_ready), .out_data(w_out)
  );

  nasti_buf_fifo #(.WIDTH($bits(b_t)), .DEPTH(B_DEPTH)) u_b (
    .clk(clk), .rstn(rstn),
    .in_valid(m.b_valid), .in_ready(m.b_ready), .in_data(b_in),
    .out_valid(s.b_valid), .out_ready(s.b_ready), .out_data(b_out)
  );

  nasti_buf_fifo #(.WIDTH($bits(r_t)), .DEPTH(R_DEPTH)) u_r (
    .clk(clk), .rstn(rstn),
    .in_valid(m.r_valid), .in_ready(m.r_ready), .in_data(r_in),
    .out_valid(s.r_valid), .out_ready(s.r_ready), .out_data(r_out)
  );

  // Outstanding counters, tracked at the upstream handshakes.
  assign aw_hs     = s.aw_valid & s.aw_ready;
  assign b_hs      = s.b_valid & s.b_ready;
  assign ar_hs     = s.ar_valid & s.ar_ready;
  assign r_last_hs = s.r_valid & s.r_ready & s.r_last;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (aw_hs && !b_hs)      wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
    else if (b_hs && !aw_hs) wr_cnt_d = wr_cnt_q - CNT_WIDTH'(1);
    if (ar_hs && !r_last_hs)      rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
    else if (r_last_hs && !ar_hs) rd_cnt_d = rd_cnt_q - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_out_cnt = wr_cnt_q;
  assign rd_out_cnt = rd_cnt_q;
endmodule

// File: doc/nasti_elastic_buf.md
# nasti_elastic_buf

Parametrised NASTI (AXI4) register-slice/FIFO placed between a NASTI master port and a slave port on the SoC interconnect. Each of the five channels (AW, AR, W, B, R) gets an independently sized FIFO, or a combinational pass-through when its depth is 0. The block also limits outstanding write and read transactions and reports the outstanding counts. It is a drop-in wherever a timing cut, an elastic buffer or a transaction throttle is needed on a `nasti_channel` link.

## Interface
Parameters:
- ID_WIDTH, 1, AXI ID width.
- ADDR_WIDTH, 8, address width.
- DATA_WIDTH, 8, data width; multiple of 8; strobe width is DATA_WIDTH/8.
- USER_WIDTH, 1, user field width; must be >0.
- AW_DEPTH, AR_DEPTH, W_DEPTH, B_DEPTH, R_DEPTH, 2 each, per-channel FIFO entries; 0 = combinational pass-through.
- CNT_WIDTH, 8, width of the outstanding counters.
- MAX_WR_OUT, 0, maximum outstanding writes; 0 = unlimited; must be < 2^CNT_WIDTH.
- MAX_RD_OUT, 0, maximum outstanding reads; 0 = unlimited; must be < 2^CNT_WIDTH.

Ports:
- clk, input, 1, single clock; all state is on the rising edge.
- rstn, input, 1, reset, asynchronous, active-low.
- s, nasti_channel.slave, —, upstream side; all five channels.
- m, nasti_channel.master, —, downstream side; all five channels.
- wr_out_cnt, output, CNT_WIDTH, accepted writes awaiting a B response.
- rd_out_cnt, output, CNT_WIDTH, accepted reads awaiting the last R beat.

## Operation
- Buffered channel (depth D>0):
  - Circular FIFO with write pointer, read pointer (range 0..D-1, wrap from D-1 to 0) and an occupancy count (0..D).
  - Push on the input-side handshake; pop on the output-side handshake.
  - Output valid = count≠0. Output payload = entry[rp].
  - Input ready = count<D.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, ready stays 0 even if a pop happens that cycle. There is no combinational path from output ready to input ready.
- Pass-through channel (D=0): all fields, valid and ready connected directly. R: m.r_ready = s.r_ready.
- Channel payloads:
  - AW/AR: id, addr, len, size, burst, lock, cache, prot, qos, region, user.
  - W: data, strb, last, user.
  - B: id, resp, user.
  - R: id, data, resp, last, user.
- Write limiter:
  - wr_out_cnt +1 on the s.aw handshake; −1 on the s.b handshake; both in the same cycle leaves it unchanged.
  - If MAX_WR_OUT>0 and wr_out_cnt==MAX_WR_OUT, s.aw_ready is forced 0. This applies in pass-through too: m.aw_valid is also masked to 0 so no handshake occurs downstream.
- Read limiter: identical, using s.ar for increments and the s.r handshake with r_last=1 for decrements. Non-last R beats do not change the count.
- W is not gated by the limiter. W and AW ordering is the master's responsibility.
- With MAX=0 the counters still run and wrap modulo 2^CNT_WIDTH. Exceeding the counter range is a system error and is not detected.

## Timing
- Reset (rstn low, asynchronous):
  - All FIFOs empty, pointers 0, wr_out_cnt=rd_out_cnt=0.
  - m.aw_valid, m.ar_valid, m.w_valid, s.b_valid, s.r_valid = 0 on buffered channels.
  - s.aw_ready, s.ar_ready, s.w_ready, m.b_ready, m.r_ready = 1 on buffered channels, unless a limit of... the limiter cannot block at reset because the counts are 0.
  - Pass-through outputs follow their inputs.
- Reset asserted mid-burst discards all buffered entries immediately. Payload storage is not reset and may hold stale data while valid=0.
- Latency through a buffered channel: 1 cycle. An input handshake at edge N gives output valid high after edge N.
- Throughput: D≥2 sustains 1 beat/cycle. D=1 sustains 1 beat per 2 cycles.
- The limiter is registered: a counter update at edge N affects s.aw_ready/s.ar_ready after edge N.
- Valid is never retracted and payload is held stable until the handshake (AXI rules) on every output channel.

## Test plan
- Reset, all depths 2: hold rstn=0 → all output valids 0, all buffered readys 1, counters 0. Release → values unchanged until stimulus.
- AW_DEPTH=2, m.aw_ready=0: push addr 0x10, 0x20, 0x30 → first two accepted, s.aw_ready=0 on the third. Then raise m.aw_ready → 0x10, 0x20 emerge in order; 0x30 is accepted the cycle after the first pop.
- R_DEPTH=3, streaming 10 beats with s.r_ready toggling randomly → all 10 beats delivered in order with data, id and last intact. After reset, no beat is dropped at pointer wrap.
- MAX_WR_OUT=2: issue 3 AWs with B responses withheld → wr_out_cnt=2, third AW stalled. Return one B → third AW accepted the next cycle and the count returns to 2.
- MAX_RD_OUT=1, len=3 read: rd_out_cnt stays 1 across beats 0–2, drops to 0 after the last beat, and the second AR is then accepted.
- All depths 0: random traffic → each output equals the corresponding input in the same cycle (zero latency) and m.r_ready tracks s.r_ready.
